// File: rtl/addsub_arbiter_pkg.sv
// Shared encodings for the add/sub arbiter: FSM states and operation codes.
package addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   OPND_W = 4;

endpackage

// File: rtl/AdderSubtractor.sv
// 4-bit ripple adder-subtractor: M=0 gives A+B, M=1 gives A-B (B inverted, carry-in 1).
module AdderSubtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [3:0] Sum,
  output logic       Carry
);

  logic [4:0] c;
  logic [3:0] bx;

  always_comb begin
    bx   = B ^ {4{M}};
    c    = '0;
    Sum  = '0;
    c[0] = M;
    for (int i = 0; i < 4; i++) begin
      Sum[i]   = A[i] ^ bx[i] ^ c[i];
      c[i + 1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
    end
    Carry = c[4];
  end

endmodule

// File: rtl/addsub_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, with wrap.
module addsub_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 4-bit adder-subtractor; one operation in flight,
// registered result returned through a per-requester valid/ready response channel.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [4*N_REQ-1:0]     req_a,
  input  logic [4*N_REQ-1:0]     req_b,
  input  logic [N_REQ-1:0]       req_sub,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [OPND_W-1:0]      rsp_sum,
  output logic                   rsp_carry,
  output logic                   rsp_ovf,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic                   busy
);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, owner, pick_idx;
  logic [N_REQ-1:0]   pick_gnt;
  logic               accept, rsp_done;

  logic signed [OPND_W-1:0] a_p0, b_p0;
  logic                     sub_p0;
  logic signed [OPND_W-1:0] sum_p1, bx_p1;
  logic                     carry_p1;

  // Overflow when both effective operands share a sign and the result flips it.
  function automatic logic ovf_calc(input logic signed [OPND_W-1:0] a,
                                    input logic signed [OPND_W-1:0] bx,
                                    input logic signed [OPND_W-1:0] s);
    return (a[OPND_W-1] == bx[OPND_W-1]) && (s[OPND_W-1] != a[OPND_W-1]);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  addsub_arbiter_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = pick_gnt;
        accept    = |pick_gnt;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (rsp_done) rr_ptr <= ptr_next(owner);
    end
  end

  // Stage p0: operands latched on accept; the adder only ever sees these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      sub_p0 <= OP_ADD;
      owner  <= '0;
    end else if (accept) begin
      a_p0   <= req_a[int'(pick_idx)*4 +: 4];
      b_p0   <= req_b[int'(pick_idx)*4 +: 4];
      sub_p0 <= req_sub[pick_idx];
      owner  <= pick_idx;
    end
  end

  AdderSubtractor u_addsub (
    .A     (a_p0),
    .B     (b_p0),
    .M     (sub_p0),
    .Sum   (sum_p1),
    .Carry (carry_p1)
  );

  assign bx_p1 = b_p0 ^ {OPND_W{sub_p0 == OP_SUB}};

  // Stage p1: result captured in EXEC and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_sum   <= sum_p1;
      rsp_carry <= carry_p1;
      rsp_ovf   <= ovf_calc(a_p0, bx_p1, sum_p1);
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: directed arithmetic, backpressure, reset and round-robin.
module tb_addsub_arbiter;

  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [4*N_REQ-1:0] req_a = '0;
  logic [4*N_REQ-1:0] req_b = '0;
  logic [N_REQ-1:0]   req_sub = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [3:0]         rsp_sum;
  logic               rsp_carry;
  logic               rsp_ovf;
  logic [N_REQ-1:0]   rsp_ready = '0;
  logic               busy;

  addsub_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         owner;
    logic [3:0] sum;
    logic       carry;
    logic       ovf;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  bit   lat_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic done on integers, independent of the gate-level formulation.
  function automatic exp_t model(input int i, input logic [3:0] a, input logic [3:0] b,
                                 input logic sub, input int c);
    exp_t e;
    int   sa, sbv, r;
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sbv = b[3] ? int'(b) - 16 : int'(b);
    if (sub) begin
      e.sum   = 4'((int'(a) - int'(b)) & 15);
      e.carry = (a >= b);
      r       = sa - sbv;
    end else begin
      e.sum   = 4'((int'(a) + int'(b)) & 15);
      e.carry = (int'(a) + int'(b)) > 15;
      r       = sa + sbv;
    end
    e.ovf   = (r > 7) || (r < -8);
    e.owner = i;
    e.acc   = c;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req_ready != 0) chk("rdy_onehot", 32'($onehot(req_ready)), 1);
      if (busy) chk("rdy_while_busy", req_ready, 0);
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i])
          sb.push_back(model(i, req_a[4*i +: 4], req_b[4*i +: 4], req_sub[i], cyc));
      if (rsp_valid != 0 && !lat_done && sb.size() > 0) begin
        chk("latency", cyc - sb[0].acc, 2);
        lat_done = 1'b1;
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner", rsp_valid, 32'(1) << e.owner);
          chk("rsp_sum", rsp_sum, e.sum);
          chk("rsp_carry", rsp_carry, e.carry);
          chk("rsp_ovf", rsp_ovf, e.ovf);
          lat_done = 1'b0;
        end
      end
    end
  end

  task automatic wait_acc(input int i);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    chk("acc_wait", req_ready[i], 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic wait_rsp(input int i);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) break;
    end
    chk("rsp_wait", rsp_valid, 32'(1) << i);
  endtask

  task automatic do_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic sub);
    @(posedge clk); #1;
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    req_sub[i]      = sub;
    req_valid[i]    = 1'b1;
    rsp_ready[i]    = 1'b1;
    wait_acc(i);
    req_valid[i] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord[5];
    int got, last;
    exp_ord = '{0, 1, 2, 3, 0};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_rsp_ovf", rsp_ovf, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(0, 4'd3, 4'd4, 1'b0);
    do_op(2, 4'd5, 4'd3, 1'b1);
    do_op(1, 4'd2, 4'd5, 1'b1);
    do_op(3, 4'h7, 4'hF, 1'b1);
    do_op(0, 4'h7, 4'h1, 1'b0);

    // Backpressure on requester 1 while requester 2 waits.
    @(posedge clk); #1;
    req_a[7:4] = 4'h9; req_b[7:4] = 4'h9; req_sub[1] = 1'b0;
    rsp_ready = '0;
    req_valid[1] = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    req_a[11:8] = 4'h4; req_b[11:8] = 4'h6; req_sub[2] = 1'b1;
    req_valid[2] = 1'b1;
    rsp_ready[2] = 1'b1;
    wait_rsp(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 4'b0010);
      chk("bp_sum", rsp_sum, 4'h2);
      chk("bp_carry", rsp_carry, 1);
      chk("bp_ovf", rsp_ovf, 1);
      chk("bp_busy", busy, 1);
      chk("bp_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_next_gnt", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_idle();

    // Asynchronous reset while a response is pending.
    @(posedge clk); #1;
    req_a[7:4] = 4'h1; req_b[7:4] = 4'h1; req_sub[1] = 1'b0;
    rsp_ready = '0;
    req_valid[1] = 1'b1;
    wait_acc(1);
    req_valid[1] = 1'b0;
    wait_rsp(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sum", rsp_sum, 0);
    chk("arst_carry", rsp_carry, 0);
    chk("arst_req_ready", req_ready, 0);
    sb.delete();
    lat_done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All requesters active with immediate response consumption.
    @(posedge clk); #1;
    req_a     = {4'hC, 4'h6, 4'h9, 4'h3};
    req_b     = {4'h5, 4'hA, 4'h7, 4'hE};
    req_sub   = 4'b1010;
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    got  = 0;
    last = 0;
    for (int k = 0; k < 40 && got < 5; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("rr_gnt", req_ready, 32'(1) << exp_ord[got]);
        if (got > 0) chk("rr_gap", cyc - last, 3);
        last = cyc;
        got++;
        if (got == 5) begin
          @(posedge clk); #1;
          req_valid = '0;
        end
      end
    end
    chk("rr_count", got, 5);
    wait_idle();
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 4-bit ripple adder-subtractor (the existing AdderSubtractor module, instantiated unchanged) among N_REQ requesters.
- Each requester submits (A, B, op) with a valid/ready handshake. It receives a registered result (sum, carry, signed overflow) through its own valid/ready response channel.
- Round-robin grant; one operation in flight at a time.
- Sits between control FSMs and the shared arithmetic unit.

Parameters:
- N_REQ, 4, number of requesters (2..8); port vectors are packed, requester i in slice i.
- PTR_W, 2, width of the round-robin pointer; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  requester i has an operation pending.
- req_a  input  4*N_REQ  operand A, requester i in bits [4i+3:4i].
- req_b  input  4*N_REQ  operand B, same packing.
- req_sub  input  N_REQ  1 = A-B, 0 = A+B; drives the adder's M input.
- req_ready  output  N_REQ  one-hot grant; accept occurs when req_valid[i] && req_ready[i].
- rsp_valid  output  N_REQ  result available for requester i.
- rsp_sum  output  4  result sum (shared bus, qualified by rsp_valid).
- rsp_carry  output  1  adder carry-out. For subtraction, 1 means no borrow (A >= B unsigned).
- rsp_ovf  output  1  two's-complement overflow.
- rsp_ready  input  N_REQ  requester i consumes the response.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - Operand/op registers cleared; owner cleared.
  - req_ready=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_ovf=0, busy=0.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational and one-hot: the first requester with req_valid=1, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ... N_REQ-1, 0, ...).
  - req_ready is all zero if no request is valid. It is never asserted outside IDLE.
  - On accept, register A, B, sub and owner index, then go to EXEC.
- EXEC (one cycle):
  - The adder sees the registered operands only; no combinational path from req_* to the adder.
  - Capture Sum and Carry into rsp_sum and rsp_carry.
  - rsp_ovf = (A[3] == Bx[3]) && (Sum[3] != A[3]), where Bx = B ^ {4{sub}}.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1, all other bits 0. rsp_sum, rsp_carry and rsp_ovf are held stable.
  - When rsp_ready[owner]=1: clear rsp_valid, set rr_ptr = owner+1 (wrapping N_REQ-1 -> 0), go to IDLE.
  - rsp_ready from non-owners is ignored.
- Latency: accept in cycle T gives rsp_valid in cycle T+2. Minimum issue interval is 3 cycles when responses are taken immediately.
- Fairness: a continuously asserted request is granted within N_REQ operations.
- req_valid dropping while another requester is in flight has no effect on that operation.
- The requester may present a new request in the same cycle rsp_ready is asserted. It is arbitrated in the next IDLE cycle, at the earliest one cycle after the response handshake.
- Asynchronous reset in EXEC or RESP discards the operation; rsp_valid drops immediately.
- Arithmetic: modulo 16; the sum is never widened.

Decomposition:
- Shared package/header:
  - State encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2. 2'd3 is illegal and recovers to IDLE.
  - OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-modules:
  - One natural sub-module, rr_pick: combinational round-robin one-hot selector (inputs: request vector, pointer; outputs: one-hot grant, encoded index).
  - AdderSubtractor is instantiated as the datapath.

Test Plan:
- Reset mid-op: rst_n low while in RESP -> all outputs 0 asynchronously; the next accepted request starts from rr_ptr=0.
- Add, no overflow: req0, A=4'd3, B=4'd4, add -> accept T, rsp_valid[0] at T+2, sum=7, carry=0, ovf=0.
- Subtract, no borrow: req2, A=4'd5, B=4'd3, sub -> sum=2, carry=1, ovf=0.
- Subtract with borrow and overflow:
  - A=4'd2, B=4'd5, sub -> sum=4'hD, carry=0, ovf=0.
  - A=4'h7, B=4'hF, sub -> sum=4'h8, ovf=1.
  - Add A=4'h7, B=4'h1 -> sum=4'h8, ovf=1, carry=0.
- Round robin: all four req_valid held high with rsp_ready tied 1 -> grant order 0,1,2,3,0; accepts every 3 cycles; req_ready never multi-hot.
- Backpressure: owner holds rsp_ready=0 for 5 cycles -> rsp_* stable, busy=1, no req_ready asserted; release -> IDLE next cycle.
